approx_mul_arbiter: RTL and testbench

APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

---
 rtl/approx_mul_arbiter.sv | 128 ++++++++++++
 tb/tb_approx_mul_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_arbiter.sv
// Two-port round-robin front end for a shared external 8x8 signed multiplier.
// Each port owns an accumulator that is either loaded with or accumulates the product.
module approx_mul_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ACC_W         = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [15:0]        req_a,
  input  logic [15:0]        req_b,
  input  logic [1:0]         req_acc,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [2*ACC_W-1:0] rsp_data,
  output logic [7:0]         mul_c,
  output logic [7:0]         mul_d,
  input  logic [15:0]        mul_result
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, last_grant_nxt;
  logic                    port, port_nxt;
  logic                    acc_mode, acc_mode_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [7:0]              mul_c_nxt, mul_d_nxt;
  logic [1:0]              rsp_valid_nxt;
  logic [1:0][ACC_W-1:0]   acc_q, acc_nxt;
  logic [1:0]              grant_c;
  logic                    sel_c;
  logic [ACC_W-1:0]        prod_c;

  // Grant: single requester wins; on contention the port not served last wins
  always_comb begin
    grant_c = 2'b00;
    sel_c   = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_c = 2'b01;
        sel_c   = 1'b0;
      end
      2'b10: begin
        grant_c = 2'b10;
        sel_c   = 1'b1;
      end
      2'b11: begin
        sel_c   = ~last_grant;
        grant_c = sel_c ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  assign req_ready = {2{(state == IDLE) & ~rst}} & grant_c;
  assign prod_c    = ACC_W'($signed(mul_result));
  assign rsp_data  = acc_q;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    port_nxt       = port;
    acc_mode_nxt   = acc_mode;
    cnt_nxt        = cnt;
    mul_c_nxt      = mul_c;
    mul_d_nxt      = mul_d;
    rsp_valid_nxt  = rsp_valid;
    acc_nxt        = acc_q;
    case (state)
      IDLE: begin
        if (|(req_valid & req_ready)) begin
          port_nxt       = sel_c;
          last_grant_nxt = sel_c;
          acc_mode_nxt   = req_acc[sel_c];
          mul_c_nxt      = sel_c ? req_a[15:8] : req_a[7:0];
          mul_d_nxt      = sel_c ? req_b[15:8] : req_b[7:0];
          cnt_nxt        = CNT_W'(SETTLE_CYCLES);
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt = cnt - CNT_W'(1);
        // Product has settled: commit it to the granted accumulator
        if (cnt <= CNT_W'(1)) begin
          acc_nxt[port]       = acc_mode ? (acc_q[port] + prod_c) : prod_c;
          rsp_valid_nxt[port] = 1'b1;
          state_nxt           = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[port]) begin
          rsp_valid_nxt = 2'b00;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port       <= 1'b0;
      acc_mode   <= 1'b0;
      cnt        <= '0;
      mul_c      <= '0;
      mul_d      <= '0;
      rsp_valid  <= 2'b00;
      acc_q      <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      port       <= port_nxt;
      acc_mode   <= acc_mode_nxt;
      cnt        <= cnt_nxt;
      mul_c      <= mul_c_nxt;
      mul_d      <= mul_d_nxt;
      rsp_valid  <= rsp_valid_nxt;
      acc_q      <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Bench for approx_mul_arbiter: two instances (SETTLE=1/ACC_W=20 and SETTLE=4/ACC_W=16)
// share stimulus; tasks observe the instance picked by sel against an arithmetic model.
module tb_approx_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_acc, rsp_ready;
  logic [15:0] req_a, req_b;
  logic        approx;
  logic        sel;

  logic [1:0]  a_req_ready, a_rsp_valid;
  logic [39:0] a_rsp_data;
  logic [7:0]  a_mul_c, a_mul_d;
  logic [15:0] a_mul_result;

  logic [1:0]  b_req_ready, b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic [7:0]  b_mul_c, b_mul_d;
  logic [15:0] b_mul_result;

  logic [1:0]  o_req_ready, o_rsp_valid;
  logic [31:0] o_acc [2];
  logic [7:0]  o_mul_c, o_mul_d;

  int          checks;
  int          failures;
  longint      mdl [2];

  approx_mul_arbiter #(.SETTLE_CYCLES(1), .ACC_W(20)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .mul_c(a_mul_c), .mul_d(a_mul_d),
    .mul_result(a_mul_result)
  );

  approx_mul_arbiter #(.SETTLE_CYCLES(4), .ACC_W(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_a(req_a), .req_b(req_b), .req_acc(req_acc), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .mul_c(b_mul_c), .mul_d(b_mul_d),
    .mul_result(b_mul_result)
  );

  // External multiplier: exact signed product, or the approximate one that drops
  // the two low bits of each operand
  function automatic logic [15:0] hw_mul(input logic [7:0] c, input logic [7:0] d, input logic apx);
    logic signed [15:0] x, y;
    x = 16'($signed(c));
    y = 16'($signed(d));
    if (apx) begin
      x[1:0] = 2'b00;
      y[1:0] = 2'b00;
    end
    return x * y;
  endfunction

  assign a_mul_result = hw_mul(a_mul_c, a_mul_d, approx);
  assign b_mul_result = hw_mul(b_mul_c, b_mul_d, approx);

  always_comb begin
    if (sel) begin
      o_req_ready = b_req_ready;
      o_rsp_valid = b_rsp_valid;
      o_acc[0]    = 32'(b_rsp_data[15:0]);
      o_acc[1]    = 32'(b_rsp_data[31:16]);
      o_mul_c     = b_mul_c;
      o_mul_d     = b_mul_d;
    end else begin
      o_req_ready = a_req_ready;
      o_rsp_valid = a_rsp_valid;
      o_acc[0]    = 32'(a_rsp_data[19:0]);
      o_acc[1]    = 32'(a_rsp_data[39:20]);
      o_mul_c     = a_mul_c;
      o_mul_d     = a_mul_d;
    end
  end

  // Reference product in plain integer arithmetic
  function automatic longint ref_prod(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    if (approx) begin
      x -= x & 3;
      y -= y & 3;
    end
    return longint'(x * y);
  endfunction

  function automatic void model_update(input int p, input logic [7:0] a, input logic [7:0] b,
                                       input logic acc);
    longint mask;
    longint pr;
    mask = (longint'(1) << (sel ? 16 : 20)) - 1;
    pr   = ref_prod(a, b);
    mdl[p] = acc ? ((mdl[p] + pr) & mask) : (pr & mask);
  endfunction

  task automatic do_reset(input logic [1:0] v);
    rst = 1'b1;
    req_valid = v;
    rsp_ready = 2'b11;
    req_acc = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mdl[0] = 0;
    mdl[1] = 0;
    #1;
  endtask

  // One complete operation on port p, with hold cycles of response backpressure
  task automatic do_op(input int p, input logic [7:0] a, input logic [7:0] b,
                       input logic acc, input int hold);
    int n;
    int s;
    logic [31:0] held;
    s = sel ? 4 : 1;
    req_a[p*8 +: 8] = a;
    req_b[p*8 +: 8] = b;
    req_acc[p] = acc;
    req_valid[p] = 1'b1;
    rsp_ready[p] = (hold == 0);
    #1;
    n = 0;
    while (o_req_ready[p] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (o_req_ready[p] !== 1'b1) begin
      failures++;
      $display("FAIL op_grant port=%0d req_ready=%b required bit set", p, o_req_ready);
      req_valid[p] = 1'b0;
      rsp_ready[p] = 1'b1;
      return;
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    req_a = 16'($urandom);
    req_b = 16'($urandom);
    model_update(p, a, b, acc);
    n = 1;
    while (o_rsp_valid[p] !== 1'b1 && n < 40) begin
      checks++;
      if (o_mul_c !== a || o_mul_d !== b || o_req_ready !== 2'b00) begin
        failures++;
        $display("FAIL op_issue mul_c=%h mul_d=%h req_ready=%b required %h %h 00",
                 o_mul_c, o_mul_d, o_req_ready, a, b);
      end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != s + 1) begin
      failures++;
      $display("FAIL op_latency cycles=%0d required %0d", n, s + 1);
    end
    checks++;
    if (o_rsp_valid !== 2'(1 << p)) begin
      failures++;
      $display("FAIL op_rsp_valid rsp_valid=%b required %b", o_rsp_valid, 2'(1 << p));
    end
    checks++;
    if (o_acc[p] !== 32'(mdl[p]) || o_acc[1-p] !== 32'(mdl[1-p])) begin
      failures++;
      $display("FAIL op_data port=%0d acc=%h other=%h required %h %h",
               p, o_acc[p], o_acc[1-p], 32'(mdl[p]), 32'(mdl[1-p]));
    end
    held = o_acc[p];
    for (int i = 0; i < hold; i++) begin
      rsp_ready[1-p] = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid[p] !== 1'b1 || o_acc[p] !== held || o_req_ready !== 2'b00) begin
        failures++;
        $display("FAIL op_hold rsp_valid=%b acc=%h req_ready=%b required 1 %h 00",
                 o_rsp_valid[p], o_acc[p], o_req_ready, held);
      end
    end
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL op_release rsp_valid=%b required 00", o_rsp_valid);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      checks++;
      if (o_req_ready !== 2'b00 || o_rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_hs dut=%0d req_ready=%b rsp_valid=%b required 00 00", s, o_req_ready, o_rsp_valid);
      end
      checks++;
      if (o_mul_c !== 8'h00 || o_mul_d !== 8'h00) begin
        failures++;
        $display("FAIL reset_mul dut=%0d mul_c=%h mul_d=%h required 00 00", s, o_mul_c, o_mul_d);
      end
      checks++;
      if (o_acc[0] !== 32'h0 || o_acc[1] !== 32'h0) begin
        failures++;
        $display("FAIL reset_acc dut=%0d acc0=%h acc1=%h required 0 0", s, o_acc[0], o_acc[1]);
      end
    end
    sel = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    sel = 1'b0;
    approx = 1'b0;
    do_reset(2'b00);
    req_a[7:0] = 8'hFD;
    req_b[7:0] = 8'h05;
    req_acc[0] = 1'b0;
    req_valid = 2'b01;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_ready req_ready=%b required 01", o_req_ready);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    checks++;
    if (o_mul_c !== 8'hFD || o_mul_d !== 8'h05 || o_rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_t1 mul_c=%h mul_d=%h rsp_valid=%b required FD 05 00", o_mul_c, o_mul_d, o_rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 2'b01 || o_acc[0] !== 32'hFFFF1 || o_acc[1] !== 32'h0) begin
      failures++;
      $display("FAIL single_t2 rsp_valid=%b acc0=%h acc1=%h required 01 FFFF1 0", o_rsp_valid, o_acc[0], o_acc[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (o_rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL single_done rsp_valid=%b required 00", o_rsp_valid);
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] exp_v [3];
    logic [7:0]  ops_a [3];
    logic [7:0]  ops_b [3];
    exp_v = '{32'd63, 32'd31, 32'd16160};
    ops_a = '{8'd7, 8'hFC, 8'd127};
    ops_b = '{8'd9, 8'd8, 8'd127};
    sel = 1'b0;
    approx = 1'b0;
    do_reset(2'b00);
    for (int i = 0; i < 3; i++) begin
      do_op(1, ops_a[i], ops_b[i], 1'b1, 0);
      checks++;
      if (o_acc[1] !== exp_v[i] || o_acc[0] !== 32'h0) begin
        failures++;
        $display("FAIL accumulate step=%0d acc1=%0d acc0=%0d required %0d 0", i, o_acc[1], o_acc[0], exp_v[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    int g, n;
    logic [7:0] ea, eb;
    logic eacc;
    sel = 1'b0;
    approx = 1'b0;
    do_reset(2'b11);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (o_req_ready === 2'b00 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (o_req_ready !== exp_g) begin
        failures++;
        $display("FAIL contention_grant op=%0d req_ready=%b required %b", k, o_req_ready, exp_g);
      end
      g = (o_req_ready === 2'b10) ? 1 : 0;
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      req_acc = 2'($urandom);
      ea = req_a[g*8 +: 8];
      eb = req_b[g*8 +: 8];
      eacc = req_acc[g];
      @(posedge clk); #1;
      model_update(g, ea, eb, eacc);
      n = 0;
      while (o_rsp_valid[g] !== 1'b1 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (o_acc[g] !== 32'(mdl[g]) || o_acc[1-g] !== 32'(mdl[1-g])) begin
        failures++;
        $display("FAIL contention_data op=%0d acc=%h other=%h required %h %h",
                 k, o_acc[g], o_acc[1-g], 32'(mdl[g]), 32'(mdl[1-g]));
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    approx = 1'b0;
    do_reset(2'b00);
    req_a[15:8] = 8'h11;
    req_b[15:8] = 8'h22;
    req_valid[1] = 1'b1;
    do_op(0, 8'h81, 8'h7F, 1'b0, 10);
    checks++;
    if (o_req_ready !== 2'b10) begin
      failures++;
      $display("FAIL backpressure_next req_ready=%b required 10", o_req_ready);
    end
    do_op(1, 8'h11, 8'h22, 1'b0, 0);
  endtask

  task automatic test_random(input logic s, input logic apx, input int nops);
    sel = s;
    approx = apx;
    do_reset(2'b00);
    for (int i = 0; i < nops; i++)
      do_op(int'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 1'($urandom),
            int'($urandom_range(2, 0)));
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    approx = 1'b0;
    do_reset(2'b00);
    repeat (5) do_op(0, 8'd127, 8'd127, 1'b1, 0);
    checks++;
    if (o_acc[0] !== 32'h3B05) begin
      failures++;
      $display("FAIL wrap acc0=%h required 3B05", o_acc[0]);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 1'b1;
    approx = 1'b0;
    do_reset(2'b00);
    do_op(1, 8'd5, 8'd5, 1'b0, 0);
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd3;
    req_acc[0] = 1'b0;
    req_valid = 2'b01;
    #1;
    n = 0;
    while (o_req_ready[0] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (o_rsp_valid !== 2'b00 || o_req_ready !== 2'b00 || o_acc[0] !== 32'h0 || o_acc[1] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid rsp_valid=%b req_ready=%b acc0=%h acc1=%h required 00 00 0 0",
               o_rsp_valid, o_req_ready, o_acc[0], o_acc[1]);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (o_rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_rsp rsp_valid=%b required 00", o_rsp_valid);
      end
    end
    rst = 1'b0;
    mdl[0] = 0;
    mdl[1] = 0;
    #1;
    checks++;
    if (o_req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_grant req_ready=%b required 01", o_req_ready);
    end
    req_valid = 2'b00;
    do_op(0, 8'h10, 8'h02, 1'b1, 0);
    checks++;
    if (o_acc[0] !== 32'd32 || o_acc[1] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_after acc0=%0d acc1=%0d required 32 0", o_acc[0], o_acc[1]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    sel = 1'b0;
    approx = 1'b0;
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = 16'h0;
    req_b = 16'h0;
    req_acc = 2'b00;
    rsp_ready = 2'b11;
    mdl[0] = 0;
    mdl[1] = 0;
    test_reset();
    test_single();
    test_accumulate();
    test_contention();
    test_backpressure();
    test_random(1'b0, 1'b0, 12);
    test_random(1'b0, 1'b1, 12);
    test_random(1'b1, 1'b1, 6);
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
